// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
//   Types shared by the branch-predictor unit.
//   PreDecType : one pre-decoded instruction slot from the fetch side.
//   BtbWrType  : one BTB write request (queue entry and output bundle).
// -----------------------------------------------------------------------------
package bp_pkg;

  import river_cfg_pkg::*;

  typedef struct packed {
    logic                  c_valid;
    logic                  jmp;
    logic [RISCV_ARCH-1:0] pc;
    logic [RISCV_ARCH-1:0] npc;
  } PreDecType;

  typedef struct packed {
    logic [RISCV_ARCH-1:0] pc;
    logic [RISCV_ARCH-1:0] npc;
    logic                  exec;
  } BtbWrType;

endpackage : bp_pkg

// File: rtl/river_cfg_pkg.sv
// -----------------------------------------------------------------------------
// river_cfg_pkg
//   Core-wide configuration constants shared by the branch-predictor blocks.
//   RISCV_ARCH : architectural address width in bits.
// -----------------------------------------------------------------------------
package river_cfg_pkg;

  localparam int RISCV_ARCH = 64;

endpackage : river_cfg_pkg

// File: rtl/bp_wr_fifo.sv
// -----------------------------------------------------------------------------
// bp_wr_fifo
//   Circular queue of BTB write requests: up to two writes and one read per
//   cycle. The caller guarantees it never over-fills or pops an empty queue.
//   Ports:
//     i_clk, i_nrst       clock, asynchronous active-low reset
//     i_flush             empty the queue (writes/read of the cycle ignored)
//     i_wr0, i_wr0_data   first (older) write
//     i_wr1, i_wr1_data   second (younger) write
//     i_rd                pop the head entry
//     o_head              current head entry
//     o_count             number of stored entries
//     o_free              DEPTH - o_count
// -----------------------------------------------------------------------------
module bp_wr_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_flush,
  input  logic             i_wr0,
  input  BtbWrType         i_wr0_data,
  input  logic             i_wr1,
  input  BtbWrType         i_wr1_data,
  input  logic             i_rd,
  output BtbWrType         o_head,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_free
);

  BtbWrType         mem_q [DEPTH];
  BtbWrType         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr1_ptr;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // The second write lands right behind the first one, or at the write
    // pointer itself when only the second port is used.
    wr1_ptr  = wr_ptr_q + PTR_W'(i_wr0);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (i_wr0) mem_d[wr_ptr_q] = i_wr0_data;
      if (i_wr1) mem_d[wr1_ptr]  = i_wr1_data;
      // Power-of-two depth: pointer arithmetic wraps naturally.
      wr_ptr_d = wr_ptr_q + PTR_W'(i_wr0) + PTR_W'(i_wr1);
      rd_ptr_d = rd_ptr_q + PTR_W'(i_rd);
      count_d  = count_q + CNT_W'(i_wr0) + CNT_W'(i_wr1) - CNT_W'(i_rd);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;
  assign o_free  = CNT_W'(DEPTH) - count_q;

endmodule : bp_wr_fifo

// File: rtl/bp_btb_wr_sched.sv
// -----------------------------------------------------------------------------
// bp_btb_wr_sched
//   BTB write scheduler. Queues eligible pre-decoded jumps (with a duplicate
//   filter), holds one executor correction, and drives the single BTB write
//   port giving the executor slot priority over the queue.
//   Ports:
//     i_clk, i_nrst          clock, asynchronous active-low reset
//     i_flush                clear queue and duplicate filter
//     i_pd0, i_pd1           pre-decode slots (older, younger)
//     i_e_jmp/i_e_pc/i_e_npc executor resolved jump
//     i_we_ready             BTB accepts the write this cycle
//     o_we/o_we_pc/o_we_npc  BTB write request
//     o_we_exec              request comes from the executor slot
//     o_full                 queue is full
//     o_drop                 registered pulse: an entry was lost for space
// -----------------------------------------------------------------------------
module bp_btb_wr_sched
  import river_cfg_pkg::*;
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_flush,
  input  PreDecType             i_pd0,
  input  PreDecType             i_pd1,
  input  logic                  i_e_jmp,
  input  logic [RISCV_ARCH-1:0] i_e_pc,
  input  logic [RISCV_ARCH-1:0] i_e_npc,
  input  logic                  i_we_ready,
  output logic                  o_we,
  output logic [RISCV_ARCH-1:0] o_we_pc,
  output logic [RISCV_ARCH-1:0] o_we_npc,
  output logic                  o_we_exec,
  output logic                  o_full,
  output logic                  o_drop
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  e_valid_q, e_valid_d;
  logic [RISCV_ARCH-1:0] e_pc_q, e_pc_d;
  logic [RISCV_ARCH-1:0] e_npc_q, e_npc_d;
  logic [RISCV_ARCH-1:0] last_pc_q, last_pc_d;
  logic                  last_pc_v_q, last_pc_v_d;
  logic                  drop_q, drop_d;

  BtbWrType         q_head;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] q_free;
  logic [CNT_W-1:0] cap;
  logic             we, hs, pop;
  logic             elig0, elig1, keep0, keep1;
  logic             have_first, have_second;
  logic             wr0, wr1;
  BtbWrType         wr0_data, wr1_data;
  BtbWrType         out_w;

  always_comb begin
    e_valid_d   = e_valid_q;
    e_pc_d      = e_pc_q;
    e_npc_d     = e_npc_q;
    last_pc_d   = last_pc_q;
    last_pc_v_d = last_pc_v_q;
    drop_d      = 1'b0;

    we  = e_valid_q | (q_count != '0);
    hs  = we & i_we_ready;
    pop = hs & ~e_valid_q;

    // A new request always takes the slot (newest wins); otherwise the slot
    // empties once its write is accepted.
    if (i_e_jmp) begin
      e_valid_d = 1'b1;
      e_pc_d    = i_e_pc;
      e_npc_d   = i_e_npc;
    end else if (hs && e_valid_q) begin
      e_valid_d = 1'b0;
    end

    // Duplicate filter. pd1 is compared against pd0 whenever pd0 is
    // eligible, even if pd0 itself was filtered against last_pc.
    elig0 = i_pd0.c_valid & i_pd0.jmp;
    elig1 = i_pd1.c_valid & i_pd1.jmp;
    keep0 = elig0 & ~(last_pc_v_q & (i_pd0.pc == last_pc_q));
    keep1 = elig1 & ~(elig0 & (i_pd1.pc == i_pd0.pc))
                  & ~(last_pc_v_q & (i_pd1.pc == last_pc_q));

    // Compact the survivors so the fifo's first port always carries the
    // oldest one; space runs out on the younger entry first.
    have_first  = keep0 | keep1;
    have_second = keep0 & keep1;
    wr0_data.pc   = keep0 ? i_pd0.pc  : i_pd1.pc;
    wr0_data.npc  = keep0 ? i_pd0.npc : i_pd1.npc;
    wr0_data.exec = 1'b0;
    wr1_data.pc   = i_pd1.pc;
    wr1_data.npc  = i_pd1.npc;
    wr1_data.exec = 1'b0;

    // pop only happens with count >= 1, so cap never exceeds DEPTH.
    cap = q_free + CNT_W'(pop);
    wr0 = ~i_flush & have_first  & (cap != '0);
    wr1 = ~i_flush & have_second & (cap >= CNT_W'(2));

    if (i_flush) begin
      last_pc_v_d = 1'b0;
    end else begin
      drop_d = (have_first & ~wr0) | (have_second & ~wr1);
      if (wr1) begin
        last_pc_d   = wr1_data.pc;
        last_pc_v_d = 1'b1;
      end else if (wr0) begin
        last_pc_d   = wr0_data.pc;
        last_pc_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      e_valid_q   <= 1'b0;
      e_pc_q      <= '0;
      e_npc_q     <= '0;
      last_pc_q   <= '0;
      last_pc_v_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      e_valid_q   <= e_valid_d;
      e_pc_q      <= e_pc_d;
      e_npc_q     <= e_npc_d;
      last_pc_q   <= last_pc_d;
      last_pc_v_q <= last_pc_v_d;
      drop_q      <= drop_d;
    end
  end

  bp_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_flush    (i_flush),
    .i_wr0      (wr0),
    .i_wr0_data (wr0_data),
    .i_wr1      (wr1),
    .i_wr1_data (wr1_data),
    .i_rd       (pop),
    .o_head     (q_head),
    .o_count    (q_count),
    .o_free     (q_free)
  );

  // Outputs decode registered state only.
  always_comb begin
    out_w = q_head;
    if (e_valid_q) begin
      out_w.pc   = e_pc_q;
      out_w.npc  = e_npc_q;
      out_w.exec = 1'b1;
    end
  end

  assign o_we      = we;
  assign o_we_pc   = out_w.pc;
  assign o_we_npc  = out_w.npc;
  assign o_we_exec = out_w.exec;
  assign o_full    = (q_count == CNT_W'(DEPTH));
  assign o_drop    = drop_q;

endmodule : bp_btb_wr_sched

// File: tb/tb_bp_btb_wr_sched.sv
module tb_bp_btb_wr_sched;
  import river_cfg_pkg::*;
  import bp_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = RISCV_ARCH;

  logic          i_clk = 1'b0;
  logic          i_nrst;
  logic          i_flush;
  PreDecType     i_pd0, i_pd1;
  logic          i_e_jmp;
  logic [AW-1:0] i_e_pc, i_e_npc;
  logic          i_we_ready;
  logic          o_we;
  logic [AW-1:0] o_we_pc, o_we_npc;
  logic          o_we_exec, o_full, o_drop;

  bp_btb_wr_sched #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_flush(i_flush),
    .i_pd0(i_pd0), .i_pd1(i_pd1),
    .i_e_jmp(i_e_jmp), .i_e_pc(i_e_pc), .i_e_npc(i_e_npc),
    .i_we_ready(i_we_ready),
    .o_we(o_we), .o_we_pc(o_we_pc), .o_we_npc(o_we_npc),
    .o_we_exec(o_we_exec), .o_full(o_full), .o_drop(o_drop)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of (pc, npc) pairs plus the executor slot.
  logic [AW-1:0] mq_pc[$];
  logic [AW-1:0] mq_npc[$];
  bit            m_ev;
  logic [AW-1:0] m_epc, m_enpc, m_last;
  bit            m_lastv, m_drop;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete(); mq_npc.delete();
    m_ev = 0; m_epc = '0; m_enpc = '0; m_last = '0; m_lastv = 0; m_drop = 0;
  endtask

  task automatic enqueue(input logic [AW-1:0] pc, input logic [AW-1:0] npc);
    if (mq_pc.size() < DEPTH) begin
      mq_pc.push_back(pc); mq_npc.push_back(npc);
      m_last = pc; m_lastv = 1;
    end else begin
      m_drop = 1;
    end
  endtask

  task automatic model_step();
    bit we, pop, e0, e1, k0, k1;
    we  = m_ev || (mq_pc.size() != 0);
    pop = we && i_we_ready && !m_ev;
    if (i_e_jmp) begin
      m_ev = 1; m_epc = i_e_pc; m_enpc = i_e_npc;
    end else if (we && i_we_ready && m_ev) begin
      m_ev = 0;
    end
    m_drop = 0;
    if (i_flush) begin
      mq_pc.delete(); mq_npc.delete(); m_lastv = 0;
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front()); void'(mq_npc.pop_front());
      end
      e0 = i_pd0.c_valid && i_pd0.jmp;
      e1 = i_pd1.c_valid && i_pd1.jmp;
      k0 = e0 && !(m_lastv && (i_pd0.pc == m_last));
      k1 = e1 && !(e0 && (i_pd1.pc == i_pd0.pc)) && !(m_lastv && (i_pd1.pc == m_last));
      if (k0) enqueue(i_pd0.pc, i_pd0.npc);
      if (k1) enqueue(i_pd1.pc, i_pd1.npc);
    end
  endtask

  task automatic check_outputs();
    bit exp_we;
    exp_we = m_ev || (mq_pc.size() != 0);
    chk("we", AW'(o_we), AW'(exp_we));
    chk("we_exec", AW'(o_we_exec), AW'(m_ev));
    chk("full", AW'(o_full), AW'(mq_pc.size() == DEPTH));
    chk("drop", AW'(o_drop), AW'(m_drop));
    if (exp_we) begin
      chk("we_pc", o_we_pc, m_ev ? m_epc : mq_pc[0]);
      chk("we_npc", o_we_npc, m_ev ? m_enpc : mq_npc[0]);
    end
  endtask

  task automatic cycle();
    check_outputs();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic clear_pd();
    i_pd0 = '0; i_pd1 = '0;
  endtask

  task automatic set_pd(input int slot, input logic [AW-1:0] pc, input logic [AW-1:0] npc);
    PreDecType p;
    p.c_valid = 1'b1; p.jmp = 1'b1; p.pc = pc; p.npc = npc;
    if (slot == 0) i_pd0 = p; else i_pd1 = p;
  endtask

  task automatic async_reset();
    #2;
    i_nrst = 1'b0;
    #1;
    model_reset();
    chk("rst_async_we", AW'(o_we), '0);
    check_outputs();
    @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
  endtask

  initial begin
    i_nrst = 1'b0; i_flush = 1'b0; i_e_jmp = 1'b0; i_e_pc = '0; i_e_npc = '0;
    i_we_ready = 1'b0;
    clear_pd();
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_we", AW'(o_we), '0);
    chk("rst_pc", o_we_pc, '0);
    chk("rst_npc", o_we_npc, '0);
    chk("rst_exec", AW'(o_we_exec), '0);
    chk("rst_full", AW'(o_full), '0);
    chk("rst_drop", AW'(o_drop), '0);
    i_nrst = 1'b1;
    @(posedge i_clk); #1;

    // First write one cycle after the pre-decode entry.
    set_pd(0, 'h1000, 'h2000);
    cycle();
    clear_pd();
    chk("first_we", AW'(o_we), 1);
    chk("first_pc", o_we_pc, 'h1000);
    chk("first_npc", o_we_npc, 'h2000);
    chk("first_exec", AW'(o_we_exec), 0);

    // Executor bypasses the queued entry.
    i_e_jmp = 1'b1; i_e_pc = 'h3000; i_e_npc = 'h3100;
    cycle();
    i_e_jmp = 1'b0;
    i_we_ready = 1'b1;
    chk("prio_exec", AW'(o_we_exec), 1);
    chk("prio_pc", o_we_pc, 'h3000);
    cycle();
    chk("prio_q_pc", o_we_pc, 'h1000);
    chk("prio_q_exec", AW'(o_we_exec), 0);
    cycle();
    chk("prio_empty", AW'(o_we), 0);
    i_we_ready = 1'b0;

    // Fill and drop.
    for (int i = 0; i < 3; i++) begin
      set_pd(0, AW'('h4000 + 16 * i), AW'('h9000 + i));
      set_pd(1, AW'('h4008 + 16 * i), AW'('h9100 + i));
      cycle();
    end
    clear_pd();
    chk("fill_full", AW'(o_full), 1);
    chk("fill_drop", AW'(o_drop), 1);
    cycle();
    i_flush = 1'b1; cycle(); i_flush = 1'b0;

    // Duplicate filter, then flush re-arms it.
    for (int i = 0; i < 3; i++) begin
      set_pd(0, 'h1000, 'h2000);
      set_pd(1, 'h1000, 'h2000);
      cycle();
    end
    clear_pd();
    i_flush = 1'b1; cycle(); i_flush = 1'b0;
    set_pd(0, 'h1000, 'h2000);
    cycle();
    clear_pd();
    chk("dup_we", AW'(o_we), 1);
    chk("dup_pc", o_we_pc, 'h1000);
    cycle();
    i_flush = 1'b1; cycle(); i_flush = 1'b0;

    // Push while full.
    for (int i = 0; i < 2; i++) begin
      set_pd(0, AW'('h6000 + 16 * i), AW'('h7000 + i));
      set_pd(1, AW'('h6008 + 16 * i), AW'('h7100 + i));
      cycle();
    end
    clear_pd();
    i_we_ready = 1'b1;
    set_pd(0, 'h5000, 'h5100);
    cycle();
    clear_pd();
    chk("pwf_full", AW'(o_full), 1);
    chk("pwf_drop", AW'(o_drop), 0);
    chk("pwf_head", o_we_pc, 'h6008);
    repeat (5) cycle();
    i_we_ready = 1'b0;

    // Flush with queued entries and a pending executor write.
    set_pd(0, 'h8000, 'h8100); set_pd(1, 'h8010, 'h8110);
    cycle();
    set_pd(0, 'h8020, 'h8120); i_pd1 = '0;
    i_e_jmp = 1'b1; i_e_pc = 'hA000; i_e_npc = 'hA100;
    cycle();
    clear_pd(); i_e_jmp = 1'b0;
    i_flush = 1'b1; cycle(); i_flush = 1'b0;
    i_we_ready = 1'b1;
    chk("flush_exec", AW'(o_we_exec), 1);
    chk("flush_pc", o_we_pc, 'hA000);
    cycle();
    chk("flush_after", AW'(o_we), 0);

    // Reset mid-burst.
    set_pd(0, 'hB000, 'hB100); set_pd(1, 'hB010, 'hB110);
    i_we_ready = 1'b0;
    cycle();
    i_e_jmp = 1'b1; i_e_pc = 'hC000; i_e_npc = 'hC100;
    cycle();
    async_reset();
    clear_pd(); i_e_jmp = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      i_pd0.c_valid = ($urandom_range(0, 3) != 0);
      i_pd0.jmp     = ($urandom_range(0, 3) != 0);
      i_pd0.pc      = AW'('h1000 + 4 * $urandom_range(0, 7));
      i_pd0.npc     = {32'h0, $urandom()};
      i_pd1.c_valid = ($urandom_range(0, 3) != 0);
      i_pd1.jmp     = ($urandom_range(0, 3) != 0);
      i_pd1.pc      = AW'('h1000 + 4 * $urandom_range(0, 7));
      i_pd1.npc     = {32'h0, $urandom()};
      i_e_jmp       = ($urandom_range(0, 5) == 0);
      i_e_pc        = {32'h0, $urandom()};
      i_e_npc       = {32'h0, $urandom()};
      i_we_ready    = ($urandom_range(0, 2) != 0);
      i_flush       = ($urandom_range(0, 40) == 0);
      if (n == 300) async_reset();
      cycle();
    end
    clear_pd(); i_e_jmp = 1'b0; i_flush = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bp_btb_wr_sched

// File: doc/bp_btb_wr_sched.md
# bp_btb_wr_sched

Write scheduler for the branch-target buffer. Collects pre-decoded jump entries (`PreDecType`) from the two fetch-side pre-decode slots into a small FIFO. Holds the executor's resolved-jump correction in a one-entry register. Arbitrates the single BTB write port between the two, executor first. Sits between the pre-decoders and the BTB inside the branch-predictor unit.

## Interface
Parameters:
- `DEPTH`, 4: pre-decode queue entries; power of two, ≥2.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_nrst`  in  1  reset, asynchronous, active-low.
- `i_flush`  in  1  pipeline flush; clears the queue and the duplicate filter.
- `i_pd0`  in  PreDecType  pre-decode slot 0, the older instruction.
- `i_pd1`  in  PreDecType  pre-decode slot 1, the younger instruction.
- `i_e_jmp`  in  1  executor resolved-jump pulse.
- `i_e_pc`  in  RISCV_ARCH  executor jump PC.
- `i_e_npc`  in  RISCV_ARCH  executor jump target.
- `i_we_ready`  in  1  BTB accepts a write this cycle.
- `o_we`  out  1  BTB write valid.
- `o_we_pc`  out  RISCV_ARCH  write PC.
- `o_we_npc`  out  RISCV_ARCH  write target.
- `o_we_exec`  out  1  current write comes from the executor slot.
- `o_full`  out  1  queue count == DEPTH.
- `o_drop`  out  1  one-cycle pulse: at least one eligible pre-decode entry was discarded for lack of space.

## Operation
- Eligible entry: `c_valid` = 1 and `jmp` = 1. Only `pc` and `npc` are stored.
- Duplicate filter (applied in slot order):
  - pd0 is dropped silently if its `pc` equals `last_pc` while `last_pc_v` = 1.
  - pd1 is dropped silently if its `pc` equals the pd0 `pc` (pd0 eligible) or equals `last_pc` (`last_pc_v` = 1).
  - `last_pc` updates to the `pc` of the youngest entry enqueued this cycle; `last_pc_v` is then set to 1.
- Executor slot (`e_valid`, `e_pc`, `e_npc`):
  - `i_e_jmp` = 1 loads the slot.
  - If the slot is already occupied and is not being written this cycle, the new request overwrites it (newest wins).
  - The slot clears when written, unless a new `i_e_jmp` arrives in the same cycle.
- Arbitration:
  - `o_we` = `e_valid` | (count != 0).
  - Source is the executor slot when `e_valid` = 1, otherwise the queue head.
  - Handshake completes when `o_we` & `i_we_ready`. A queue-sourced handshake is a pop.
- Capacity per cycle: DEPTH − count + pop. Push 0, 1 or 2 entries in pd0-then-pd1 order. Entries beyond capacity are discarded; pd1 is discarded first. Any discard pulses `o_drop`.
- Queue: read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count is $clog2(DEPTH+1) bits.
- Flush:
  - Count, pointers and `last_pc_v` go to 0.
  - Same-cycle pushes are ignored.
  - The executor slot is kept, and a same-cycle `i_e_jmp` still loads it.
  - A same-cycle pop is irrelevant because the queue is emptied.
- Reset: all registers 0. Outputs after reset: `o_we`=0, `o_we_pc`=0, `o_we_npc`=0, `o_we_exec`=0, `o_full`=0, `o_drop`=0.

## Timing
- Input to `o_we`: 1 cycle. An input sampled at edge N is visible on the outputs after edge N.
- `o_we`, `o_we_pc`, `o_we_npc`, `o_we_exec` and `o_full` are decoded only from registered state. No combinational path from any input.
- `o_drop` is registered and asserts in the cycle after the discard.
- Write order:
  - Queue-sourced writes leave in enqueue order.
  - Executor writes may bypass queued entries.
  - With `i_we_ready` held at 1, a continuous executor stream starves the queue; this is intended.
- Throughput: one BTB write per cycle with `i_we_ready` = 1. Steady state accepts at most one queue pop per cycle.
- Asynchronous reset mid-operation discards all pending entries and the executor slot immediately.

## Structure
- `bp_pkg` gains a `BtbWrType` struct {`pc`, `npc`, `exec`}, used for the queue entries and the output bundle.
- `RISCV_ARCH` comes from `river_cfg_pkg`.
- One natural sub-module: `bp_wr_fifo`. A 2-write, 1-read circular queue, parameterised by DEPTH, that reports free space.
- Arbitration and the duplicate filter stay in the top module.

## Test plan
- **Reset and first write.** Reset, then pd0 {c_valid=1, jmp=1, pc=0x1000, npc=0x2000} for one cycle → next cycle `o_we`=1, `o_we_pc`=0x1000, `o_we_npc`=0x2000, `o_we_exec`=0.
- **Executor priority.** `i_we_ready`=0; queue holds 0x1000; `i_e_jmp` with pc=0x3000, npc=0x3100 → on `i_we_ready`=1: 0x3000 with `o_we_exec`=1 first, then 0x1000 the following cycle.
- **Fill and drop.** DEPTH=4, `i_we_ready`=0; pd0 and pd1 eligible with distinct PCs for 3 cycles → `o_full`=1 after 2 cycles. The third cycle produces an `o_drop` pulse; the count stays 4.
- **Duplicate filter.** pd0.pc = pd1.pc = 0x1000, repeated over 3 cycles → exactly one entry queued and no `o_drop`. A flush, then the same pd0 → one more entry queued.
- **Push while full.** Full queue, `i_we_ready`=1, one new eligible pd0 → the pop and push happen together. `o_full` stays 1, no drop, order preserved.
- **Flush and reset mid-operation.**
  - `i_flush` with 3 entries queued and `e_valid`=1 → only the executor write follows.
  - Assert `i_nrst`=0 mid-burst → `o_we`=0 immediately.
